sr_latch_bist: RTL and testbench

//   Built-in self-test driver/checker for a gate-level NOR SR latch (active-high S/R).

---
 rtl/sr_latch_bist.sv | 188 ++++++++++++++++++
 tb/tb_sr_latch_bist.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_bist.sv
// sr_latch_bist: BIST driver/checker for a NOR SR latch.
// Define SR_BIST_FORBIDDEN_EN to add the forbidden S=R=1 step and its recovery.
module sr_latch_bist #(
    parameter int SETTLE_CYC = 2,
    parameter int NUM_PASSES = 1,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             q_in,
    input  logic             qn_in,
    output logic             s_out,
    output logic             r_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       fail_step
);

`ifdef SR_BIST_FORBIDDEN_EN
    localparam logic [2:0] LAST_STEP = 3'd6;
`else
    localparam logic [2:0] LAST_STEP = 3'd4;
`endif

    localparam int PC_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int WC_W = $clog2(SETTLE_CYC + 2) + 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(NUM_PASSES - 1);
    localparam logic [WC_W-1:0] WC_LOAD = WC_W'(SETTLE_CYC + 1);
    localparam logic [2:0] NO_FAIL = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    // {S, R, expected Q, expected Qn} for each step
    function automatic logic [3:0] step_vec(input logic [2:0] idx);
        logic [3:0] v;
        case (idx)
            3'd0:    v = 4'b0101;
            3'd1:    v = 4'b0001;
            3'd2:    v = 4'b1010;
            3'd3:    v = 4'b0010;
            3'd4:    v = 4'b0101;
`ifdef SR_BIST_FORBIDDEN_EN
            3'd5:    v = 4'b1100;
            3'd6:    v = 4'b0101;
`endif
            default: v = 4'b0101;
        endcase
        return v;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [PC_W-1:0]  pcnt_q, pcnt_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [2:0]       fail_q, fail_d;
    logic [1:0]       sync1_q, sync2_q;
    logic [3:0]       vec;

    assign vec = step_vec(step_q);

    // Next-state and registered-output logic for the test sequencer
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        pcnt_d  = pcnt_q;
        wcnt_d  = wcnt_q;
        s_d     = s_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_APPLY;
                    busy_d  = 1'b1;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    fail_d  = NO_FAIL;
                    step_d  = 3'd0;
                    pcnt_d  = '0;
                end
            end
            ST_APPLY: begin
                s_d     = vec[3];
                r_d     = vec[2];
                wcnt_d  = WC_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            ST_CHECK: begin
                if (sync2_q != vec[1:0]) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (fail_q == NO_FAIL) begin
                        fail_d = step_q;
                    end
                end
                state_d = ST_APPLY;
                if (step_q == LAST_STEP) begin
                    step_d = 3'd0;
                    if (pcnt_q == PC_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_d == '0);
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, output and Q/Qn synchroniser registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= 3'd0;
            pcnt_q  <= '0;
            wcnt_q  <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= NO_FAIL;
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            pcnt_q  <= pcnt_d;
            wcnt_q  <= wcnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            sync1_q <= {q_in, qn_in};
            sync2_q <= sync1_q;
        end
    end

    assign s_out     = s_q;
    assign r_out     = r_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign fail_step = fail_q;

endmodule

// File: tb/tb_sr_latch_bist.sv
// tb_sr_latch_bist: scoreboard bench for sr_latch_bist.
// Latch is modelled behaviourally with selectable faults.
module tb_sr_latch_bist;

`ifdef SR_BIST_FORBIDDEN_EN
    localparam int N = 7;
`else
    localparam int N = 5;
`endif
    localparam int TOT     = N * 6;
    localparam int SAT_TOT = N * 6 * 4;

    typedef struct {
        int cyc;
        int pass;
        int err;
        int fail;
    } exp_t;

    exp_t sb[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       q_in, qn_in;
    logic       s_out, r_out, busy, done, pass;
    logic [7:0] err_cnt;
    logic [2:0] fail_step;

    logic       start_sat = 1'b0;
    logic       q_sat, qn_sat;
    logic       s_sat, r_sat, busy_sat, done_sat, pass_sat;
    logic [1:0] err_sat;
    logic [2:0] fail_sat;

    int  n_tests = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  mode = 0;
    logic lq = 1'b0;
    logic lq2 = 1'b0;

    sr_latch_bist u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .q_in(q_in), .qn_in(qn_in),
        .s_out(s_out), .r_out(r_out),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_step(fail_step)
    );

    sr_latch_bist #(.SETTLE_CYC(2), .NUM_PASSES(4), .ERR_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_sat),
        .q_in(q_sat), .qn_in(qn_sat),
        .s_out(s_sat), .r_out(r_sat),
        .busy(busy_sat), .done(done_sat), .pass(pass_sat),
        .err_cnt(err_sat), .fail_step(fail_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Latch storage: set/reset dominate, otherwise hold
    always @(s_out or r_out) begin
        if (s_out && !r_out) lq = 1'b1;
        else if (r_out && !s_out) lq = 1'b0;
    end

    always @(s_sat or r_sat) begin
        if (s_sat && !r_sat) lq2 = 1'b1;
        else if (r_sat && !s_sat) lq2 = 1'b0;
    end

    // mode 0 ideal, 1 Q stuck-at-0, 2 Q=~Qn on S=R=1
    always_comb begin
        q_in  = lq;
        qn_in = ~lq;
        if (s_out && r_out) begin
            q_in  = 1'b0;
            qn_in = (mode == 2);
        end
        if (mode == 1) q_in = 1'b0;
    end

    always_comb begin
        q_sat  = 1'b0;
        qn_sat = ~lq2;
        if (s_sat && r_sat) qn_sat = 1'b0;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Pop expected result on every done pulse
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cyc", cyc, e.cyc);
                chk("pass", {31'd0, pass}, e.pass);
                chk("err_cnt", {24'd0, err_cnt}, e.err);
                chk("fail_step", {29'd0, fail_step}, e.fail);
                chk("busy_at_done", {31'd0, busy}, 0);
            end
        end
    end

    task automatic start_run(input int ep, input int ee,
                             input int ef, input bit push);
        exp_t e;
        start = 1'b1;
        if (push) begin
            e.cyc  = cyc + 1 + TOT;
            e.pass = ep;
            e.err  = ee;
            e.fail = ef;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++)
            @(negedge clk);
        @(negedge clk);
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        int d0;
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_s", {31'd0, s_out}, 0);
        chk("rst_r", {31'd0, r_out}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_pass", {31'd0, pass}, 0);
        chk("rst_err", {24'd0, err_cnt}, 0);
        chk("rst_fail", {29'd0, fail_step}, 7);
        rst_n = 1'b1;
        @(negedge clk);

        // ideal latch
        mode = 0;
        start_run(1, 0, 7, 1);
        chk("busy_run", {31'd0, busy}, 1);
        drain(200);
        chk("s_end", {31'd0, s_out}, 0);
        chk("r_end", {31'd0, r_out}, 1);

        // Q stuck-at-0
        mode = 1;
        start_run(0, 2, 2, 1);
        drain(200);

        // Q=~Qn on forbidden input
        mode = 2;
`ifdef SR_BIST_FORBIDDEN_EN
        start_run(0, 1, 5, 1);
`else
        start_run(1, 0, 7, 1);
`endif
        drain(200);

        // reset during WAIT of step 3
        mode = 1;
        start_run(0, 0, 0, 0);
        repeat (20) @(negedge clk);
        chk("busy_pre_rst", {31'd0, busy}, 1);
        chk("err_pre_rst", {24'd0, err_cnt}, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_s", {31'd0, s_out}, 0);
        chk("abort_r", {31'd0, r_out}, 1);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_err", {24'd0, err_cnt}, 0);
        chk("abort_fail", {29'd0, fail_step}, 7);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        repeat (60) @(negedge clk);
        start_run(1, 0, 7, 1);
        drain(200);

        // start held high: back-to-back runs
        start = 1'b1;
        d0 = cyc + 1 + TOT;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.cyc  = d0 + k * (TOT + 2);
            e.pass = 1;
            e.err  = 0;
            e.fail = 7;
            sb.push_back(e);
        end
        while (cyc < d0 + 2 * (TOT + 2)) @(negedge clk);
        start = 1'b0;
        drain(200);

        // start pulses while busy are ignored
        start_run(1, 0, 7, 1);
        for (int k = 0; k < 4; k++) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        drain(200);
        repeat (60) @(negedge clk);
        chk("no_extra_run", {31'd0, busy}, 0);

        // saturation on narrow counter
        start_sat = 1'b1;
        d0 = cyc + 1 + SAT_TOT;
        @(negedge clk);
        start_sat = 1'b0;
        seen = 0;
        for (int i = 0; i < SAT_TOT + 50 && !seen; i++) begin
            @(negedge clk);
            if (done_sat) seen = 1;
        end
        chk("sat_done_seen", {31'd0, seen}, 1);
        chk("sat_done_cyc", cyc, d0);
        chk("sat_err", {30'd0, err_sat}, 3);
        chk("sat_fail", {29'd0, fail_sat}, 2);
        chk("sat_pass", {31'd0, pass_sat}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
